// File: rtl/fp_writeback_buffer_if.sv
// Bundle between the FPU result path, the register-file read ports and the
// writeback buffer.
//
// Handshake: an entry transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready depends only on registered buffer state.
// in_valid while in_ready=0 is dropped. The write side has no ready: wen is
// the register-file write strobe, and the head entry retires on every edge
// where wen=1.
interface fp_writeback_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_addr;
  logic [63:0]   in_data;
  logic [4:0]    raddr1;
  logic [4:0]    raddr2;
  logic [4:0]    raddr3;
  logic [4:0]    waddr;
  logic [63:0]   wdata;
  logic          wen;
  logic [31:0]   pending;
  logic          starve;
  logic [CW-1:0] count;

  // Buffer side
  modport slave (
    input  in_valid, in_addr, in_data, raddr1, raddr2, raddr3,
    output in_ready, waddr, wdata, wen, pending, starve, count
  );

  // FPU / register-file side
  modport master (
    output in_valid, in_addr, in_data, raddr1, raddr2, raddr3,
    input  in_ready, waddr, wdata, wen, pending, starve, count
  );
endinterface

// File: rtl/fp_writeback_buffer.sv
// FP register writeback buffer: a small circular FIFO of {addr,data} results.
// The head entry is written to the register file on any cycle in which its
// destination is not being read, so writes never collide with read ports.
// pending flags every register with an outstanding write for hazard logic.
module fp_writeback_buffer #(
  parameter int DEPTH     = 4,
  parameter int STALL_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_writeback_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] STALL_C = SW'(STALL_MAX);

  logic [4:0]       addr_q [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    stall_q, stall_d;

  logic        not_empty;
  logic        conflict;
  logic        push;
  logic        pop;
  logic [4:0]  head_addr;
  logic [63:0] head_data;
  logic [31:0] pending_c;

  assign not_empty = (count_q != '0);
  // Head fields are forced to zero when empty so the bus never shows stale data.
  assign head_addr = not_empty ? addr_q[rd_ptr_q] : 5'd0;
  assign head_data = not_empty ? data_q[rd_ptr_q] : 64'd0;
  assign conflict  = (head_addr == bus.raddr1) || (head_addr == bus.raddr2) ||
                     (head_addr == bus.raddr3);
  assign pop       = not_empty && !conflict;
  assign push      = bus.in_valid && bus.in_ready;

  assign bus.in_ready = (count_q < DEPTH_C);
  assign bus.waddr    = head_addr;
  assign bus.wdata    = head_data;
  assign bus.wen      = pop;
  assign bus.pending  = pending_c;
  assign bus.starve   = (stall_q == STALL_C);
  assign bus.count    = count_q;

  // Payload storage; occupancy is tracked by valid_q so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.in_addr;
      data_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // Next-state for pointers, occupancy, count and head-blocked counter.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop || !not_empty) begin
      stall_d = '0;
    end else if (conflict && (stall_q != STALL_C)) begin
      stall_d = stall_q + SW'(1);
    end
  end

  // State registers; reset drops every queued entry immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Outstanding-write mask: one bit per register targeted by any live entry.
  always_comb begin
    pending_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pending_c[addr_q[i]] = 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_writeback_buffer.sv
// Bench for fp_writeback_buffer: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_fp_writeback_buffer;
  localparam int DEPTH     = 4;
  localparam int STALL_MAX = 15;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_writeback_buffer_if #(.DEPTH(DEPTH)) bus ();

  fp_writeback_buffer #(
    .DEPTH    (DEPTH),
    .STALL_MAX(STALL_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: queued {addr,data} entries in arrival order, plus the
  // number of consecutive edges the head has been held back.
  logic [68:0] exp_q[$];
  int          blocked;
  int          checks;
  int          errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_conflict();
    logic [4:0] h;
    if (exp_q.size() == 0) return 1'b0;
    h = exp_q[0][68:64];
    return (h == bus.raddr1) || (h == bus.raddr2) || (h == bus.raddr3);
  endfunction

  task automatic check_all();
    logic [31:0] pend;
    logic        has;
    pend = '0;
    foreach (exp_q[i]) pend[exp_q[i][68:64]] = 1'b1;
    has = (exp_q.size() > 0);
    check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < DEPTH));
    check("count",    64'(bus.count),    64'(exp_q.size()));
    check("wen",      64'(bus.wen),      64'(has && !model_conflict()));
    check("waddr",    64'(bus.waddr),    has ? 64'(exp_q[0][68:64]) : 64'd0);
    check("wdata",    bus.wdata,         has ? exp_q[0][63:0] : 64'd0);
    check("pending",  64'(bus.pending),  64'(pend));
    check("starve",   64'(bus.starve),   64'(blocked == STALL_MAX));
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cycle();
    logic        cf, do_pop, do_push;
    logic [68:0] ent;
    int          sz;
    @(negedge clk);
    check_all();
    sz      = exp_q.size();
    cf      = model_conflict();
    do_pop  = (sz > 0) && !cf;
    do_push = bus.in_valid && (sz < DEPTH) && !rst;
    ent     = {bus.in_addr, bus.in_data};
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      blocked = 0;
    end else begin
      if (do_pop || sz == 0) blocked = 0;
      else if (cf && blocked < STALL_MAX) blocked++;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(ent);
    end
    #1;
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [4:0] a, input logic [63:0] d);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
  endtask

  task automatic set_raddr(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    bus.raddr1 = a;
    bus.raddr2 = b;
    bus.raddr3 = c;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    blocked = 0;
    drive(1'b0, 5'd0, 64'd0);
    set_raddr(5'd0, 5'd0, 5'd0);
    rst = 1'b1;

    // Reset state, with in_valid asserted to confirm it is ignored under reset
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_wen",      64'(bus.wen),      64'd0);
    check("rst_pending",  64'(bus.pending),  64'd0);
    drive(1'b1, 5'd4, 64'h1234);
    cycle();
    cycle();
    drive(1'b0, 5'd0, 64'd0);
    rst = 1'b0;

    // Single write through, register 5
    set_raddr(5'd1, 5'd2, 5'd3);
    drive(1'b1, 5'd5, 64'h3FF0000000000000);
    cycle();
    drive(1'b0, 5'd0, 64'd0);
    check("t33_wen",     64'(bus.wen),     64'd1);
    check("t33_waddr",   64'(bus.waddr),   64'd5);
    check("t33_pending", 64'(bus.pending), 64'h20);
    cycle();
    check("t33_count",   64'(bus.count),   64'd0);
    check("t33_pend0",   64'(bus.pending), 64'd0);
    cycle();

    // Head blocked by a read port long enough to starve, then released
    set_raddr(5'd0, 5'd7, 5'd0);
    drive(1'b1, 5'd7, rnd64());
    cycle();
    drive(1'b0, 5'd0, 64'd0);
    repeat (20) cycle();
    check("t34_starve", 64'(bus.starve), 64'd1);
    check("t34_wen0",   64'(bus.wen),    64'd0);
    set_raddr(5'd0, 5'd8, 5'd0);
    #1;
    check("t34_wen1",   64'(bus.wen),    64'd1);
    cycle();
    check("t34_starve0", 64'(bus.starve), 64'd0);
    check("t34_count",   64'(bus.count),  64'd0);

    // Fill to full behind a blocked head, drop a fifth entry, drain in order
    set_raddr(5'd11, 5'd11, 5'd11);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(11 + i), rnd64());
      cycle();
    end
    check("t35_count",    64'(bus.count),    64'd4);
    check("t35_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 5'd15, rnd64());
    cycle();
    drive(1'b0, 5'd0, 64'd0);
    check("t35_dropped",  64'(bus.count),    64'd4);
    set_raddr(5'd31, 5'd31, 5'd31);
    repeat (5) cycle();
    check("t35_ready1",   64'(bus.in_ready), 64'd1);

    // Two writes to the same register; pending bit held until the second pops
    set_raddr(5'd1, 5'd1, 5'd1);
    drive(1'b1, 5'd9, 64'hAAAA_AAAA_AAAA_AAAA);
    cycle();
    drive(1'b1, 5'd9, 64'hBBBB_BBBB_BBBB_BBBB);
    cycle();
    drive(1'b0, 5'd0, 64'd0);
    check("t36_pend9",  64'(bus.pending[9]), 64'd1);
    check("t36_wdataB", bus.wdata,           64'hBBBB_BBBB_BBBB_BBBB);
    cycle();
    check("t36_pend9c", 64'(bus.pending[9]), 64'd0);
    cycle();

    // Steady push+pop at count=2 with pointers wrapping
    set_raddr(5'd20, 5'd20, 5'd20);
    drive(1'b1, 5'd20, rnd64());
    cycle();
    drive(1'b1, 5'd21, rnd64());
    cycle();
    set_raddr(5'd31, 5'd31, 5'd31);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'($urandom_range(0, 30)), rnd64());
      cycle();
      check("t37_count", 64'(bus.count), 64'd2);
    end
    drive(1'b0, 5'd0, 64'd0);
    repeat (3) cycle();

    // Random traffic with a narrow address range to provoke conflicts
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), rnd64());
      if ((i / 40) % 3 == 1) set_raddr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      else set_raddr(5'($urandom_range(0, 31)), 5'($urandom_range(8, 31)), 5'($urandom_range(8, 31)));
      cycle();
    end
    drive(1'b0, 5'd0, 64'd0);
    set_raddr(5'd31, 5'd31, 5'd31);
    repeat (6) cycle();

    // Asynchronous reset with three entries queued
    set_raddr(5'd3, 5'd3, 5'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(3 + i), rnd64());
      cycle();
    end
    drive(1'b0, 5'd0, 64'd0);
    check("t38_count3", 64'(bus.count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check("t38_wen",      64'(bus.wen),      64'd0);
    check("t38_count",    64'(bus.count),    64'd0);
    check("t38_pending",  64'(bus.pending),  64'd0);
    check("t38_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    blocked = 0;
    set_raddr(5'd31, 5'd31, 5'd31);
    cycle();
    cycle();
    rst = 1'b0;
    repeat (5) cycle();

    // Push accepted on the first edge after reset release
    drive(1'b1, 5'd6, 64'hCAFE_F00D_0000_0006);
    cycle();
    drive(1'b0, 5'd0, 64'd0);
    check("t32_wen",   64'(bus.wen),   64'd1);
    check("t32_wdata", bus.wdata,      64'hCAFE_F00D_0000_0006);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_writeback_buffer.md
FP_WRITEBACK_BUFFER -- requirements
Module: fp_writeback_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queued write entries (power of two, 2..16).
REQ-002 SHALL have parameter STALL_MAX, default 15, meaning head-blocked cycle count at which starve asserts.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  FPU result valid.
REQ-006 SHALL have port in_ready  output  1  buffer can accept an entry.
REQ-007 SHALL have port in_addr  input  5  destination FP register.
REQ-008 SHALL have port in_data  input  64  result value.
REQ-009 SHALL have port raddr1, raddr2, raddr3  input  5 each  register-file read addresses in the current cycle.
REQ-010 SHALL have port waddr  output  5  register-file write address.
REQ-011 SHALL have port wdata  output  64  register-file write data.
REQ-012 SHALL have port wen  output  1  register-file write enable.
REQ-013 SHALL have port pending  output  32  bit i set while any queued entry targets register i.
REQ-014 SHALL have port starve  output  1  head blocked for at least STALL_MAX consecutive cycles.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of queued entries.

Function
REQ-016 SHALL store entries in a circular FIFO with write and read pointers that wrap modulo DEPTH.
REQ-017 SHALL drive in_ready = (count < DEPTH), from registered state only.
REQ-018 SHALL push {in_addr,in_data} on a rising edge where in_valid && in_ready; an in_valid while in_ready=0 SHALL be ignored and the entry not stored.
REQ-019 SHALL drive waddr/wdata from the head entry whenever count>0; both SHALL be 0 when empty.
REQ-020 SHALL compute conflict = (waddr==raddr1)||(waddr==raddr2)||(waddr==raddr3), combinationally from the current raddr inputs.
REQ-021 SHALL drive wen = (count>0) && !conflict, combinationally.
REQ-022 SHALL pop the head on a rising edge where wen=1.
REQ-023 SHALL add one cycle minimum latency: an entry pushed at edge N drives wen no earlier than the cycle after edge N, with no bypass from input to output.
REQ-024 SHALL, on simultaneous push and pop in one edge, leave count unchanged and advance both pointers.
REQ-025 SHALL preserve order: entries are written strictly in arrival order, including multiple entries to the same register.
REQ-026 SHALL derive pending as the OR over valid entries of onehot(addr), combinationally from registered state; the bit clears only after the last matching entry pops.
REQ-027 SHALL use a stall counter that increments (saturating at STALL_MAX) each edge where count>0 && conflict, and clears on any pop or when empty.
REQ-028 SHALL drive starve = (stall counter == STALL_MAX); starve SHALL NOT stop blocking the write.
REQ-029 SHALL have no special case for register 0: it is a normal FP register.

Reset
REQ-030 SHALL, while rst=1, immediately clear pointers, count, stall counter and entry valid state, giving in_ready=1, wen=0, waddr=0, wdata=0, pending=0, starve=0, count=0.
REQ-031 SHALL discard all queued entries on a reset asserted mid-operation, with no write issued during or after it.
REQ-032 SHALL accept a push on the first rising edge after rst deasserts.

Verification
REQ-033 Push addr=5, data=0x3FF0000000000000 with raddr1..3 = 1,2,3 -> next cycle wen=1, waddr=5, pending[5]=1; the following cycle count=0, pending=0.
REQ-034 Push addr=7 with raddr2=7 held for 20 cycles -> wen=0 throughout, starve=1 from cycle 15 of blocking; raddr2 changes to 8 -> wen=1 that cycle, starve=0 after the pop.
REQ-035 Push 4 entries with all raddr=addr of the first entry -> count=4, in_ready=0; a fifth in_valid is dropped; release raddr -> 4 writes in order, then in_ready=1.
REQ-036 Push addr=9 data=A, then addr=9 data=B -> writes A then B; pending[9] stays 1 until B pops.
REQ-037 Continuous push and pop with count=2 for 10 cycles and pointers wrapping -> count stays 2 and data order is preserved.
REQ-038 Assert rst with 3 entries queued -> same cycle wen=0, count=0, pending=0; after release no stale write occurs.
